// File: rtl/hazard_pkg.sv
// Shared types for the pipeline data-hazard controller: forwarding mux
// selects and the MDU tracker state encoding.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_t;

endpackage

// File: rtl/hazard_unit_mdu_tracker.sv
// Tracks one in-flight multiply/divide operation: busy window, one-cycle
// done pulse and a sticky overrun flag for starts issued while busy.
module mdu_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MDU_LATENCY = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic start_i,
  output logic busy_o,
  output logic done_o,
  output logic overrun_o
);

  localparam int CW = (MDU_LATENCY > 2) ? $clog2(MDU_LATENCY) : 1;

  mdu_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic          overrun_q, overrun_d;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  // The count reaching zero marks the result-valid cycle; a start there is
  // a legal back-to-back launch rather than an overrun.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    done_d    = 1'b0;
    overrun_d = overrun_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = BUSY;
          cnt_d   = CW'(MDU_LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt_q == '0) begin
          if (start_i) begin
            cnt_d = CW'(MDU_LATENCY - 1);
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            done_d = 1'b1;
          end
          if (start_i) begin
            overrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy_o    = (state_q == BUSY);
  assign done_o    = done_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/hazard_unit.sv
// Data-hazard controller: EX operand forwarding, load-use and MDU stall
// generation, and a saturating count of stalled cycles.
module hazard_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW      = 5,
  parameter int NUM_SRC     = 2,
  parameter int MDU_LATENCY = 4,
  parameter int CNT_W       = 32
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic [NUM_SRC-1:0][REG_AW-1:0]  dec_ex_src_i,
  input  logic [NUM_SRC-1:0][REG_AW-1:0]  if_dec_src_i,
  input  logic [NUM_SRC-1:0]              if_dec_src_used_i,
  input  logic [REG_AW-1:0]               dec_ex_rd_i,
  input  logic                            dec_ex_memread_i,
  input  logic [REG_AW-1:0]               ex_mem_rd_i,
  input  logic [REG_AW-1:0]               mem_wb_rd_i,
  input  logic                            ex_mem_regwrite_i,
  input  logic                            mem_wb_regwrite_i,
  input  logic                            if_dec_mdu_op_i,
  input  logic                            mdu_start_i,
  output logic [NUM_SRC-1:0][1:0]         forward_o,
  output logic                            stall_dec_o,
  output logic                            flush_ex_o,
  output logic                            mdu_busy_o,
  output logic                            mdu_done_o,
  output logic                            mdu_overrun_o,
  output logic [CNT_W-1:0]                stall_cycles_o
);

  logic [NUM_SRC-1:0] loadUse;
  logic               loadUseHazard;
  logic               mduHazard;
  logic               stall;
  logic [CNT_W-1:0]   stall_cycles_q, stall_cycles_d;

  // Register 0 is hardwired to zero, so it never forwards or stalls.
  for (genvar i = 0; i < NUM_SRC; i++) begin : gSrc
    fwd_sel_t fwdSel;

    always_comb begin
      fwdSel = FWD_RF;
      if (ex_mem_regwrite_i && (ex_mem_rd_i != '0) && (ex_mem_rd_i == dec_ex_src_i[i])) begin
        fwdSel = FWD_MEM;
      end else if (mem_wb_regwrite_i && (mem_wb_rd_i != '0) && (mem_wb_rd_i == dec_ex_src_i[i])) begin
        fwdSel = FWD_WB;
      end
    end

    assign forward_o[i] = fwdSel;
    assign loadUse[i]   = dec_ex_memread_i && (dec_ex_rd_i != '0) &&
                          (dec_ex_rd_i == if_dec_src_i[i]) && if_dec_src_used_i[i];
  end

  mdu_busy_tracker #(
    .MDU_LATENCY (MDU_LATENCY)
  ) uTracker (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .start_i   (mdu_start_i),
    .busy_o    (mdu_busy_o),
    .done_o    (mdu_done_o),
    .overrun_o (mdu_overrun_o)
  );

  assign loadUseHazard = |loadUse;
  assign mduHazard     = if_dec_mdu_op_i && (mdu_busy_o || mdu_start_i);
  assign stall         = loadUseHazard || mduHazard;
  assign stall_dec_o   = stall;
  assign flush_ex_o    = stall;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      stall_cycles_q <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: forwarding/load-use vector table plus
// hand-written MDU latency, overrun, saturation and mid-operation reset runs.
module tb_hazard_unit;

  typedef struct {
    logic [4:0] s0;
    logic [4:0] s1;
    logic [4:0] d0;
    logic [4:0] d1;
    logic [1:0] used;
    logic [4:0] drd;
    logic       memread;
    logic [4:0] exrd;
    logic       exwr;
    logic [4:0] wbrd;
    logic       wbwr;
    logic       mduop;
    logic [1:0] f0;
    logic [1:0] f1;
    logic       stall;
  } vec_t;

  logic            clk;
  logic            reset;
  logic [1:0][4:0] dec_ex_src;
  logic [1:0][4:0] if_dec_src;
  logic [1:0]      if_dec_src_used;
  logic [4:0]      dec_ex_rd;
  logic            dec_ex_memread;
  logic [4:0]      ex_mem_rd;
  logic [4:0]      mem_wb_rd;
  logic            ex_mem_regwrite;
  logic            mem_wb_regwrite;
  logic            if_dec_mdu_op;
  logic            mdu_start;
  logic [1:0][1:0] forward;
  logic            stall_dec;
  logic            flush_ex;
  logic            mdu_busy;
  logic            mdu_done;
  logic            mdu_overrun;
  logic [3:0]      stall_cycles;

  int   total;
  int   bad;
  int   expCount;
  vec_t vecs[13];
  vec_t idleVec;

  hazard_unit #(
    .REG_AW      (5),
    .NUM_SRC     (2),
    .MDU_LATENCY (4),
    .CNT_W       (4)
  ) dut (
    .clk_i             (clk),
    .reset_i           (reset),
    .dec_ex_src_i      (dec_ex_src),
    .if_dec_src_i      (if_dec_src),
    .if_dec_src_used_i (if_dec_src_used),
    .dec_ex_rd_i       (dec_ex_rd),
    .dec_ex_memread_i  (dec_ex_memread),
    .ex_mem_rd_i       (ex_mem_rd),
    .mem_wb_rd_i       (mem_wb_rd),
    .ex_mem_regwrite_i (ex_mem_regwrite),
    .mem_wb_regwrite_i (mem_wb_regwrite),
    .if_dec_mdu_op_i   (if_dec_mdu_op),
    .mdu_start_i       (mdu_start),
    .forward_o         (forward),
    .stall_dec_o       (stall_dec),
    .flush_ex_o        (flush_ex),
    .mdu_busy_o        (mdu_busy),
    .mdu_done_o        (mdu_done),
    .mdu_overrun_o     (mdu_overrun),
    .stall_cycles_o    (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", name, got, expv);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    dec_ex_src[0]   = v.s0;
    dec_ex_src[1]   = v.s1;
    if_dec_src[0]   = v.d0;
    if_dec_src[1]   = v.d1;
    if_dec_src_used = v.used;
    dec_ex_rd       = v.drd;
    dec_ex_memread  = v.memread;
    ex_mem_rd       = v.exrd;
    ex_mem_regwrite = v.exwr;
    mem_wb_rd       = v.wbrd;
    mem_wb_regwrite = v.wbwr;
    if_dec_mdu_op   = v.mduop;
  endtask

  task automatic bumpCount(input logic stallExp);
    if (stallExp && expCount != 15) expCount++;
  endtask

  // One clock of MDU activity with load-use inputs idle.
  task automatic mduCycle(input logic start, input logic mduop, input logic eBusy,
                          input logic eDone, input logic eOvr, input logic eStall);
    @(posedge clk);
    #1;
    mdu_start     = start;
    if_dec_mdu_op = mduop;
    @(negedge clk);
    checkOutput("mdu_busy", 32'(mdu_busy), 32'(eBusy));
    checkOutput("mdu_done", 32'(mdu_done), 32'(eDone));
    checkOutput("mdu_overrun", 32'(mdu_overrun), 32'(eOvr));
    checkOutput("mdu_stall", 32'(stall_dec), 32'(eStall));
    checkOutput("mdu_stall_cycles", 32'(stall_cycles), 32'(expCount));
    bumpCount(eStall);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    expCount = 0;

    idleVec  = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
    vecs[0]  = '{5'd8, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 5'd8, 1'b1, 5'd8, 1'b1, 1'b0, 2'b10, 2'b00, 1'b0};
    vecs[1]  = '{5'd8, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 5'd8, 1'b0, 5'd8, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0};
    vecs[2]  = '{5'd3, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
    vecs[3]  = '{5'd4, 5'd7, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 5'd7, 1'b1, 5'd4, 1'b1, 1'b0, 2'b01, 2'b10, 1'b0};
    vecs[4]  = '{5'd4, 5'd4, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 5'd4, 1'b0, 5'd4, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
    vecs[5]  = '{5'd0, 5'd0, 5'd0, 5'd5, 2'b10, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1};
    vecs[6]  = '{5'd0, 5'd0, 5'd9, 5'd5, 2'b01, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
    vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b11, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
    vecs[8]  = '{5'd0, 5'd0, 5'd0, 5'd5, 2'b11, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0};
    vecs[9]  = '{5'd0, 5'd0, 5'd9, 5'd0, 2'b01, 5'd9, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1};
    vecs[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0};
    vecs[11] = '{5'd6, 5'd6, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 5'd6, 1'b1, 5'd6, 1'b1, 1'b0, 2'b10, 2'b10, 1'b0};
    vecs[12] = '{5'd5, 5'd3, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 5'd3, 1'b1, 5'd5, 1'b1, 1'b0, 2'b01, 2'b10, 1'b0};

    reset     = 1'b1;
    mdu_start = 1'b0;
    applyStimulus(idleVec);
    #2;
    checkOutput("reset_busy", 32'(mdu_busy), 32'd0);
    checkOutput("reset_done", 32'(mdu_done), 32'd0);
    checkOutput("reset_overrun", 32'(mdu_overrun), 32'd0);
    checkOutput("reset_stall_cycles", 32'(stall_cycles), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 13; i++) begin
      @(posedge clk);
      #1;
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_fwd0", i), 32'(forward[0]), 32'(vecs[i].f0));
      checkOutput($sformatf("vec%0d_fwd1", i), 32'(forward[1]), 32'(vecs[i].f1));
      checkOutput($sformatf("vec%0d_stall", i), 32'(stall_dec), 32'(vecs[i].stall));
      checkOutput($sformatf("vec%0d_flush", i), 32'(flush_ex), 32'(vecs[i].stall));
      checkOutput($sformatf("vec%0d_cycles", i), 32'(stall_cycles), 32'(expCount));
      bumpCount(vecs[i].stall);
    end

    @(posedge clk);
    #1;
    applyStimulus(idleVec);
    mduCycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("table_stall_total", 32'(stall_cycles), 32'd2);

    // MDU latency with the decode instruction waiting on the MDU.
    mduCycle(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    mduCycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    mduCycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    mduCycle(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    mduCycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    mduCycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    mduCycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Second start two cycles into BUSY: sticky overrun, done timing unchanged.
    mduCycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    mduCycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    mduCycle(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    mduCycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    mduCycle(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    mduCycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    mduCycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Long load-use stall drives the 4-bit counter into saturation.
    @(posedge clk);
    #1;
    applyStimulus(vecs[5]);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("sat_stall", 32'(stall_dec), 32'd1);
    checkOutput("sat_cycles", 32'(stall_cycles), 32'hF);
    @(posedge clk);
    #1;
    applyStimulus(idleVec);
    expCount = 15;
    mduCycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    mduCycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    checkOutput("sat_held", 32'(stall_cycles), 32'hF);

    // Asynchronous reset two cycles into a BUSY window.
    mduCycle(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    mduCycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    mduCycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("async_busy", 32'(mdu_busy), 32'd0);
    checkOutput("async_done", 32'(mdu_done), 32'd0);
    checkOutput("async_overrun", 32'(mdu_overrun), 32'd0);
    checkOutput("async_cycles", 32'(stall_cycles), 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    expCount = 0;
    for (int k = 0; k < 6; k++) begin
      mduCycle(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
